// File: rtl/ddr_ex_lfsr8_pkg.sv
// rtl/ddr_ex_lfsr8_pkg.sv - shared 8-bit Galois LFSR (poly 0x1D) definitions
// Used by the example-driver generator and the read-path checker.
package ddr_ex_lfsr8_pkg;

  localparam logic [7:0] LFSR8_POLY   = 8'h1D;
  localparam logic [7:0] LFSR8_LOCKUP = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    SYNC   = 2'd2,
    LOCKED = 2'd3
  } lfsr_chk_state_t;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] d);
    return {d[6:0], 1'b0} ^ (d[7] ? LFSR8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ddr_ex_lfsr8_checker.sv
// rtl/ddr_ex_lfsr8_checker.sv - self-synchronising LFSR8 read-data checker
// Optional first-error capture outputs under DDR_EX_LFSR_CHK_CAPTURE_EN.
module ddr_ex_lfsr8_checker
  import ddr_ex_lfsr8_pkg::*;
#(
  parameter int unsigned SEED     = 32,
  parameter int unsigned SYNC_LEN = 4,
  parameter int unsigned LOSS_LEN = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             valid,
  input  logic [7:0]       data,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       expected
`ifdef DDR_EX_LFSR_CHK_CAPTURE_EN
  ,
  output logic             first_err_vld,
  output logic [7:0]       first_err_data,
  output logic [7:0]       first_err_exp
`endif
);

  localparam logic [7:0] SEED8     = SEED[7:0];
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_LEN);

  lfsr_chk_state_t state;
  logic [3:0]      run_cnt;
  logic [3:0]      miss_cnt;
  logic            match;
  logic            count_hit;

  assign match     = (data == expected);
  // Only mismatches seen while locked are real data errors; earlier ones are acquisition noise.
  assign count_hit = enable && valid && (state == LOCKED) && !match;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      expected  <= SEED8;
      run_cnt   <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      error <= count_hit;

      if (clear)
        err_count <= '0;
      else if (count_hit && (err_count != '1))
        err_count <= err_count + ERR_W'(1);

      if (!enable) begin
        state    <= IDLE;
        expected <= SEED8;
        run_cnt  <= 4'd0;
        miss_cnt <= 4'd0;
        locked   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= HUNT;

          HUNT: begin
            if (valid && (data != LFSR8_LOCKUP)) begin
              expected <= lfsr8_next(data);
              run_cnt  <= 4'd1;
              state    <= SYNC;
            end
          end

          SYNC: begin
            if (valid) begin
              if (match) begin
                expected <= lfsr8_next(expected);
                run_cnt  <= run_cnt + 4'd1;
                if ((run_cnt + 4'd1) == SYNC_LAST) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  miss_cnt <= 4'd0;
                end
              end else if (data != LFSR8_LOCKUP) begin
                expected <= lfsr8_next(data);
                run_cnt  <= 4'd1;
              end else begin
                run_cnt <= 4'd0;
                state   <= HUNT;
              end
            end
          end

          LOCKED: begin
            if (valid) begin
              // Keep free-running so a lone corrupted byte cannot desynchronise us.
              expected <= lfsr8_next(expected);
              if (match) begin
                miss_cnt <= 4'd0;
              end else if ((miss_cnt + 4'd1) == LOSS_LAST) begin
                miss_cnt <= 4'd0;
                run_cnt  <= 4'd0;
                locked   <= 1'b0;
                state    <= HUNT;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DDR_EX_LFSR_CHK_CAPTURE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_err_vld  <= 1'b0;
      first_err_data <= 8'h00;
      first_err_exp  <= 8'h00;
    end else if (clear) begin
      first_err_vld  <= 1'b0;
      first_err_data <= 8'h00;
      first_err_exp  <= 8'h00;
    end else if (count_hit && !first_err_vld) begin
      first_err_vld  <= 1'b1;
      first_err_data <= data;
      first_err_exp  <= expected;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_ex_lfsr8_checker.sv
// tb/tb_ddr_ex_lfsr8_checker.sv - directed table-driven bench for the LFSR8 checker
// Capture checks enabled when DDR_EX_LFSR_CHK_CAPTURE_EN is defined.
module tb_ddr_ex_lfsr8_checker;

  localparam int ERR_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic             valid = 1'b0;
  logic [7:0]       data = 8'h00;
  logic             locked;
  logic             error;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       expected;
`ifdef DDR_EX_LFSR_CHK_CAPTURE_EN
  logic             first_err_vld;
  logic [7:0]       first_err_data;
  logic [7:0]       first_err_exp;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr_ex_lfsr8_checker #(
    .SEED(32), .SYNC_LEN(4), .LOSS_LEN(4), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .valid(valid), .data(data), .locked(locked), .error(error),
    .err_count(err_count), .expected(expected)
`ifdef DDR_EX_LFSR_CHK_CAPTURE_EN
    , .first_err_vld(first_err_vld), .first_err_data(first_err_data),
    .first_err_exp(first_err_exp)
`endif
  );

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       vld;
    logic [7:0] d;
    logic       lk;
    logic       er;
    logic [3:0] cnt;
    logic [7:0] ex;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic logic [7:0] nxt(input logic [7:0] d);
    return {d[6:0], 1'b0} ^ (d[7] ? 8'h1D : 8'h00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic beat(input logic e, input logic c, input logic v, input logic [7:0] d);
    @(negedge clk);
    enable = e; clear = c; valid = v; data = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] mexp;
  int         want;

  initial begin
    //            en clr vld data   lk er cnt  exp
    tbl[0]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,4'd0,8'h20}; // IDLE->HUNT
    tbl[1]  = '{1'b1,1'b0,1'b1,8'h20, 1'b0,1'b0,4'd0,8'h40};
    tbl[2]  = '{1'b1,1'b0,1'b1,8'h40, 1'b0,1'b0,4'd0,8'h80};
    tbl[3]  = '{1'b1,1'b0,1'b1,8'h80, 1'b0,1'b0,4'd0,8'h1D};
    tbl[4]  = '{1'b1,1'b0,1'b1,8'h1D, 1'b1,1'b0,4'd0,8'h3A}; // lock
    tbl[5]  = '{1'b1,1'b0,1'b0,8'h55, 1'b1,1'b0,4'd0,8'h3A}; // gap
    tbl[6]  = '{1'b1,1'b0,1'b0,8'h66, 1'b1,1'b0,4'd0,8'h3A}; // gap
    tbl[7]  = '{1'b1,1'b0,1'b1,8'h3A, 1'b1,1'b0,4'd0,8'h74};
    tbl[8]  = '{1'b1,1'b0,1'b1,8'h75, 1'b1,1'b1,4'd1,8'hE8}; // bad byte
    tbl[9]  = '{1'b1,1'b0,1'b1,8'hE8, 1'b1,1'b0,4'd1,8'hCD};
    tbl[10] = '{1'b1,1'b0,1'b1,8'hCD, 1'b1,1'b0,4'd1,8'h87};
    tbl[11] = '{1'b1,1'b0,1'b1,8'h00, 1'b1,1'b1,4'd2,8'h13};
    tbl[12] = '{1'b1,1'b0,1'b1,8'h00, 1'b1,1'b1,4'd3,8'h26};
    tbl[13] = '{1'b1,1'b0,1'b1,8'h00, 1'b1,1'b1,4'd4,8'h4C};
    tbl[14] = '{1'b1,1'b0,1'b1,8'h00, 1'b0,1'b1,4'd5,8'h98}; // loss of lock
    tbl[15] = '{1'b1,1'b0,1'b1,8'h00, 1'b0,1'b0,4'd5,8'h98}; // lockup ignored
    tbl[16] = '{1'b1,1'b0,1'b1,8'h00, 1'b0,1'b0,4'd5,8'h98};
    tbl[17] = '{1'b1,1'b0,1'b1,8'h20, 1'b0,1'b0,4'd5,8'h40};
    tbl[18] = '{1'b1,1'b0,1'b1,8'h40, 1'b0,1'b0,4'd5,8'h80};
    tbl[19] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,4'd5,8'h80};
    tbl[20] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,4'd5,8'h20}; // enable drop
    tbl[21] = '{1'b0,1'b0,1'b1,8'h80, 1'b0,1'b0,4'd5,8'h20};
    tbl[22] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,4'd5,8'h20};
    tbl[23] = '{1'b1,1'b0,1'b1,8'h20, 1'b0,1'b0,4'd5,8'h40};
    tbl[24] = '{1'b1,1'b0,1'b1,8'h41, 1'b0,1'b0,4'd5,8'h82}; // reseed in SYNC
    tbl[25] = '{1'b1,1'b0,1'b1,8'h82, 1'b0,1'b0,4'd5,8'h19};
    tbl[26] = '{1'b1,1'b0,1'b1,8'h00, 1'b0,1'b0,4'd5,8'h19}; // zero -> HUNT
    tbl[27] = '{1'b1,1'b1,1'b0,8'h00, 1'b0,1'b0,4'd0,8'h19}; // clear

    repeat (2) @(posedge clk);
    #1;
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_count", 32'(err_count), 32'd0);
    chk("reset_expected", 32'(expected), 32'h20);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      beat(tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].d);
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
      chk($sformatf("v%0d_error", i), 32'(error), 32'(tbl[i].er));
      chk($sformatf("v%0d_count", i), 32'(err_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_expected", i), 32'(expected), 32'(tbl[i].ex));
    end

    // Relock from HUNT, then drive errors interleaved with good beats to saturate the count.
    beat(1, 0, 1, 8'h20);
    beat(1, 0, 1, 8'h40);
    beat(1, 0, 1, 8'h80);
    beat(1, 0, 1, 8'h1D);
    chk("relock", 32'(locked), 32'd1);
    mexp = 8'h3A;
    for (int i = 1; i <= 20; i++) begin
      beat(1, 0, 1, mexp ^ 8'hFF);
      mexp = nxt(mexp);
      want = (i > 15) ? 15 : i;
      chk($sformatf("sat_count_%0d", i), 32'(err_count), 32'(want));
      chk($sformatf("sat_error_%0d", i), 32'(error), 32'd1);
      beat(1, 0, 1, mexp);
      mexp = nxt(mexp);
    end
    chk("sat_locked", 32'(locked), 32'd1);
    chk("sat_expected", 32'(expected), 32'(mexp));

    beat(1, 1, 1, mexp ^ 8'h01);
    mexp = nxt(mexp);
    chk("clr_mismatch_error", 32'(error), 32'd1);
    chk("clr_mismatch_count", 32'(err_count), 32'd0);
    beat(1, 0, 1, mexp ^ 8'h01);
    chk("post_clr_count", 32'(err_count), 32'd1);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_locked", 32'(locked), 32'd0);
    chk("areset_error", 32'(error), 32'd0);
    chk("areset_count", 32'(err_count), 32'd0);
    chk("areset_expected", 32'(expected), 32'h20);
    @(negedge clk);
    reset_n = 1'b1;

    beat(1, 0, 0, 8'h00);
    beat(1, 0, 1, 8'h20);
    beat(1, 0, 1, 8'h40);
    beat(1, 0, 1, 8'h80);
    beat(1, 0, 1, 8'h1D);
    beat(1, 0, 1, 8'h3A);
    beat(1, 0, 1, 8'h75);
    chk("cap1_count", 32'(err_count), 32'd1);
`ifdef DDR_EX_LFSR_CHK_CAPTURE_EN
    chk("cap1_vld", 32'(first_err_vld), 32'd1);
    chk("cap1_data", 32'(first_err_data), 32'h75);
    chk("cap1_exp", 32'(first_err_exp), 32'h74);
`endif
    beat(1, 0, 1, 8'h00);
    chk("cap2_count", 32'(err_count), 32'd2);
    chk("cap2_error", 32'(error), 32'd1);
`ifdef DDR_EX_LFSR_CHK_CAPTURE_EN
    chk("cap2_vld", 32'(first_err_vld), 32'd1);
    chk("cap2_data", 32'(first_err_data), 32'h75);
    chk("cap2_exp", 32'(first_err_exp), 32'h74);
`endif
    beat(1, 1, 0, 8'h00);
    chk("cap_clr_count", 32'(err_count), 32'd0);
`ifdef DDR_EX_LFSR_CHK_CAPTURE_EN
    chk("cap_clr_vld", 32'(first_err_vld), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_ex_lfsr8_checker.md
Name: ddr_ex_lfsr8_checker

Overview:
- Receive-side companion of the 8-bit example-driver LFSR pattern generator; sits on the DDR example read-data return path.
- Self-synchronises to an incoming LFSR byte stream, then compares every valid beat against the locally predicted value.
- Reports lock status, per-beat error pulses and a saturating error count for the example pass/fail logic.

Parameters:
- SEED, 32, generator reset/disable value; its low 8 bits are used; the expected register resets to it.
- SYNC_LEN, 4, consecutive predicted beats (seed beat included) required to declare lock; range 2..15.
- LOSS_LEN, 4, consecutive mismatches while locked that drop lock; range 1..15.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  checker enable; low forces IDLE
- clear  in  1  synchronous clear of err_count and (if compiled) the capture registers
- valid  in  1  data beat qualifier
- data  in  8  received LFSR byte
- locked  out  1  registered; high while state is LOCKED
- error  out  1  registered one-cycle pulse per mismatching beat while LOCKED
- err_count  out  ERR_W  saturating count of error pulses
- expected  out  8  current predicted byte (debug)

Behaviour:
- Next-state function is Galois, polynomial 0x1D: nxt = {d[6:0],1'b0} ^ (d[7] ? 8'h1D : 8'h00). This is bit-identical to the generator.
- Reference sequence from 0x20: 20,40,80,1D,3A,74,E8,CD.
- Reset values: state IDLE, expected = SEED[7:0], run_cnt 0, miss_cnt 0, locked 0, error 0, err_count 0.
- FSM states: IDLE, HUNT, SYNC, LOCKED. Beats with valid=0 change nothing (equivalent to the generator's pause).
- IDLE: enable=1 moves to HUNT next cycle.
- HUNT, on valid:
  - data==0x00 (LFSR lockup value): ignored, stay in HUNT.
  - otherwise: expected <= nxt(data), run_cnt <= 1, go to SYNC.
- SYNC, on valid:
  - match (data==expected): expected <= nxt(expected), run_cnt++. If run_cnt+1 == SYNC_LEN, go to LOCKED; locked rises the cycle after that beat.
  - mismatch, data non-zero: reseed with expected <= nxt(data), run_cnt <= 1, stay in SYNC.
  - mismatch, data==0: go to HUNT.
- LOCKED, on valid:
  - expected always advances to nxt(expected), so a single corrupted byte does not desynchronise the checker.
  - match: miss_cnt <= 0.
  - mismatch: error=1 on the next cycle; err_count++ (saturates at all-ones, never wraps); miss_cnt++.
  - If miss_cnt+1 == LOSS_LEN: go to HUNT, locked falls the next cycle, miss_cnt <= 0.
- enable=0 in any state: next cycle state IDLE, expected <= SEED, run/miss counters 0, locked 0. err_count holds.
- clear: err_count <= 0. If a counted mismatch occurs in the same cycle, clear wins and the count stays 0; the error pulse still fires.
- Errors in SYNC/HUNT are not counted.
- Asynchronous reset mid-stream returns all registers to reset values immediately.

Optional Feature:
- Macro DDR_EX_LFSR_CHK_CAPTURE_EN.
- Defined: adds outputs first_err_vld (1), first_err_data (8), first_err_exp (8).
  - On the first counted mismatch after reset or clear, latches data and expected, sets first_err_vld.
  - Later errors do not overwrite; clear or reset empties the capture.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package ddr_ex_lfsr8_pkg holds: the polynomial constant 8'h1D; function lfsr8_next(d); the state enum {IDLE,HUNT,SYNC,LOCKED}; the lockup constant 8'h00.
- The generator should later reuse lfsr8_next.
- No sub-module; single module.

Test Plan:
- Reset, enable=1, stream 20,40,80,1D contiguous: locked rises the cycle after beat 1D; error never asserts; err_count=0.
- After lock, send 3A,75(bad),E8,CD: one error pulse the cycle after 75; err_count=1; locked stays 1; expected continues to E8.
- After lock, four consecutive bytes 00: err_count +4; locked falls after the 4th; state HUNT; further 00 beats are ignored.
- Insert valid=0 gaps between 1D and 3A, and drop enable mid-SYNC: gaps leave state unchanged; enable drop gives IDLE and expected=0x20 next cycle, with err_count preserved.
- Force err_count to all-ones (ERR_W=4 build, 20 errors): saturates at 0xF. Assert clear together with a mismatch: count=0, error pulse present.
- With CAPTURE_EN, errors 75 (exp 74) then 00 (exp E8): first_err_data=75, first_err_exp=74, unchanged after the second error; clear resets first_err_vld to 0.
